fp_sum_tree: RTL and testbench
==============================

FP_SUM_TREE -- requirements
Module: fp_sum_tree

Interface
REQ-001 SHALL have parameter NUM_IN, default 10, meaning number of FP32 operands summed per beat (legal range 2..64).
REQ-002 SHALL have localparam LEVELS = ceil(log2(NUM_IN)) and localparam LATENCY = LEVELS + 2, meaning input-to-output delay in cycles.
REQ-003 SHALL have port clk, input, 1, sole clock (rising edge).
REQ-004 SHALL have port rst, input, 1, reset; one clock; asynchronous, active-high.
REQ-005 SHALL have port input_valid, input, 1, beat present on data_in.
REQ-006 SHALL have port input_last, input, 1, final beat of an accumulation group (ignored when acc_mode=0).
REQ-007 SHALL have port input_ready, output, 1, beat accepted when input_valid & input_ready.
REQ-008 SHALL have port data_in, input, NUM_IN*32, packed IEEE-754 single operands; operand k at bits [32k+31:32k].
REQ-009 SHALL have port acc_mode, input, 1, 0 = per-beat sum, 1 = sum across beats until last.
REQ-010 SHALL have port output_valid, output, 1, data_out holds a result.
REQ-011 SHALL have port output_ready, input, 1, downstream accepts result.
REQ-012 SHALL have port data_out, output, 32, FP32 result.

Function
REQ-013 SHALL register data_in, input_valid, input_last and acc_mode on acceptance (stage 0).
REQ-014 SHALL reduce pairwise per level: element 2i with 2i+1; an odd trailing element is registered unchanged into the next level.
REQ-015 SHALL register every tree level; valid, last and mode travel alongside the data in lockstep.
REQ-016 SHALL, after the tree, add the tree result to a 32-bit accumulator register in a final registered stage (fp_adder, AddBar_Sub=0).
REQ-017 SHALL, with mode=0, output the tree result (accumulator not used, not modified) with output_valid asserted LATENCY cycles after acceptance, absent stalls.
REQ-018 SHALL, with mode=1, add each valid tree result into the accumulator; output_valid asserts only for the last-tagged beat, data_out = accumulator + that beat's sum; accumulator clears to +0.0 in the same cycle.
REQ-019 SHALL treat mode as per beat: a mode=0 beat arriving mid-group passes through without touching the accumulator.
REQ-020 SHALL advance the whole pipeline when adv = output_ready | ~output_valid; input_ready = adv; on ~adv every stage register, including the accumulator, holds.
REQ-021 SHALL keep data_out/output_valid stable while output_valid & ~output_ready.
REQ-022 SHALL sustain one beat per cycle with output_ready held high.
REQ-023 SHALL produce bit-identical results to the fixed pairing order of REQ-014 (no reassociation).

Reset
REQ-024 SHALL, on rst, clear all stage valids, output_valid=0, data_out=32'h0, accumulator=+0.0, input_ready=1 after release.
REQ-025 SHALL discard all in-flight beats and any partial accumulation group on rst.

Structure
REQ-026 SHALL place FP32 constants (FP_ZERO, FP_ONE) and the LEVELS/LATENCY function in shared package fp_pkg.
REQ-027 SHALL instantiate the existing combinational fp_adder for every pairwise add and the accumulator add; no other sub-module.
REQ-028 SHALL build the tree with generate loops over NUM_IN; no hand-unrolled levels.

Verification
REQ-029 NUM_IN=10, mode 0, all operands 32'h3F800000, one beat -> data_out 32'h41200000 (10.0), output_valid exactly 6 cycles after acceptance.
REQ-030 NUM_IN=8, operands 1.0..8.0, back-to-back 4 beats, output_ready=1 -> four results 32'h42100000 (36.0) on consecutive cycles.
REQ-031 NUM_IN=10, mode 1, three beats all 1.0, last on beat 3 -> single output 32'h41F00000 (30.0); next group starts from 0.0.
REQ-032 output_ready=0 for 5 cycles with pipeline full -> input_ready=0, data_out held, no beat lost or duplicated after release.
REQ-033 operands x and -x pairs (32'h40400000/32'hC0400000) -> data_out 32'h00000000.
REQ-034 rst asserted mid accumulation group with beats in flight -> output_valid=0 immediately; next group of one last beat of all 1.0 yields 10.0, no stale contribution.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the summation tree.
// Contents: FP32 constants, the per-stage sideband struct, and the constant
// functions that size the reduction tree (level count, latency, level widths).
package fp_pkg;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  // Sideband that travels with each beat through every pipeline stage.
  typedef struct packed {
    logic valid;
    logic last;
    logic mode;
  } beat_ctrl_t;

  // ceil(log2(n)) for the legal operand range 2..64.
  function automatic int unsigned fp_levels(input int unsigned n);
    int unsigned lv;
    lv = 0;
    for (int unsigned k = 0; k < 7; k++) begin
      if ((32'd1 << k) < n) lv = k + 1;
    end
    return lv;
  endfunction

  // Input-to-output delay: input stage + one per tree level + final stage.
  function automatic int unsigned fp_latency(input int unsigned n);
    return fp_levels(n) + 2;
  endfunction

  // Number of live elements at a tree level (level 0 = registered inputs).
  function automatic int unsigned fp_level_width(input int unsigned n,
                                                 input int unsigned lvl);
    int unsigned w;
    w = n;
    for (int unsigned k = 0; k < lvl; k++) begin
      w = (w + 1) / 2;
    end
    return w;
  endfunction

endpackage

// File: rtl/fp_adder.sv
// Combinational IEEE-754 single-precision adder/subtractor, round-to-nearest-even.
// Ports:
//   i_a, i_b    : FP32 operands
//   AddBar_Sub  : 0 = i_a + i_b, 1 = i_a - i_b
//   o_sum       : FP32 result (NaN/Inf propagated, subnormals supported)
module fp_adder
  import fp_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        AddBar_Sub,
  output logic [31:0] o_sum
);

  logic        w_sa, w_sb, w_sl, w_ss, w_same;
  logic [7:0]  w_ea, w_eb, w_ediff;
  logic [9:0]  w_el, w_es, w_e_norm, w_e_fin;
  logic [23:0] w_ma, w_mb, w_ml, w_ms;
  logic [26:0] w_ml_x, w_ms_x, w_ms_sh, w_mask, w_n27;
  logic [27:0] w_s28;
  logic [4:0]  w_lz, w_sft;
  logic [24:0] w_m25;
  logic [22:0] w_frac;
  logic        w_inc, w_hidden;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;

  // Align, add/subtract with guard/round/sticky, normalize, round, pack.
  always_comb begin
    w_sa     = i_a[31];
    w_sb     = i_b[31] ^ AddBar_Sub;
    w_ea     = i_a[30:23];
    w_eb     = i_b[30:23];
    w_ma     = {(w_ea != 8'd0), i_a[22:0]};
    w_mb     = {(w_eb != 8'd0), i_b[22:0]};
    w_a_nan  = (w_ea == 8'hFF) && (i_a[22:0] != 23'd0);
    w_b_nan  = (w_eb == 8'hFF) && (i_b[22:0] != 23'd0);
    w_a_inf  = (w_ea == 8'hFF) && (i_a[22:0] == 23'd0);
    w_b_inf  = (w_eb == 8'hFF) && (i_b[22:0] == 23'd0);
    w_sl     = 1'b0;
    w_ss     = 1'b0;
    w_el     = 10'd0;
    w_es     = 10'd0;
    w_ml     = 24'd0;
    w_ms     = 24'd0;
    w_ms_sh  = 27'd0;
    w_mask   = 27'd0;
    w_n27    = 27'd0;
    w_lz     = 5'd27;
    w_sft    = 5'd0;
    w_e_norm = 10'd0;
    w_e_fin  = 10'd0;
    w_frac   = 23'd0;
    w_hidden = 1'b0;

    // Larger magnitude goes to the "l" side; subnormals use exponent 1.
    if (i_a[30:0] >= i_b[30:0]) begin
      w_sl = w_sa;  w_ss = w_sb;
      w_el = {2'b00, (w_ea == 8'd0) ? 8'd1 : w_ea};
      w_es = {2'b00, (w_eb == 8'd0) ? 8'd1 : w_eb};
      w_ml = w_ma;  w_ms = w_mb;
    end else begin
      w_sl = w_sb;  w_ss = w_sa;
      w_el = {2'b00, (w_eb == 8'd0) ? 8'd1 : w_eb};
      w_es = {2'b00, (w_ea == 8'd0) ? 8'd1 : w_ea};
      w_ml = w_mb;  w_ms = w_ma;
    end
    w_same  = (w_sl == w_ss);
    w_ediff = 8'(w_el - w_es);
    w_ml_x  = {w_ml, 3'b000};
    w_ms_x  = {w_ms, 3'b000};

    // Shift the smaller operand right, folding lost bits into the sticky bit.
    if (w_ediff >= 8'd27) begin
      w_ms_sh = {26'd0, |w_ms};
    end else begin
      w_mask  = (27'd1 << w_ediff) - 27'd1;
      w_ms_sh = (w_ms_x >> w_ediff) | {26'd0, |(w_ms_x & w_mask)};
    end

    w_s28 = w_same ? ({1'b0, w_ml_x} + {1'b0, w_ms_sh})
                   : ({1'b0, w_ml_x} - {1'b0, w_ms_sh});

    // Carry-out shifts right once; cancellation shifts left, but never
    // below exponent 1 so tiny results land as subnormals.
    if (w_s28[27]) begin
      w_n27    = w_s28[27:1] | {26'd0, w_s28[0]};
      w_e_norm = w_el + 10'd1;
    end else begin
      w_n27 = w_s28[26:0];
      for (int i = 0; i < 27; i++) begin
        if (w_n27[i]) w_lz = 5'(26 - i);
      end
      w_sft    = ({5'd0, w_lz} > (w_el - 10'd1)) ? 5'(w_el - 10'd1) : w_lz;
      w_n27    = w_n27 << w_sft;
      w_e_norm = w_el - {5'd0, w_sft};
    end

    w_inc = w_n27[2] & ((|w_n27[1:0]) | w_n27[3]);
    w_m25 = {1'b0, w_n27[26:3]} + {24'd0, w_inc};
    if (w_m25[24]) begin
      w_e_fin  = w_e_norm + 10'd1;
      w_frac   = w_m25[23:1];
      w_hidden = 1'b1;
    end else begin
      w_e_fin  = w_e_norm;
      w_frac   = w_m25[22:0];
      w_hidden = w_m25[23];
    end

    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb))) begin
      o_sum = FP_QNAN;
    end else if (w_a_inf) begin
      o_sum = {w_sa, 8'hFF, 23'd0};
    end else if (w_b_inf) begin
      o_sum = {w_sb, 8'hFF, 23'd0};
    end else if (w_s28 == 28'd0) begin
      // Exact cancellation yields +0; like-signed zeros keep their sign.
      o_sum = {w_same ? w_sl : 1'b0, 31'd0};
    end else if (w_e_fin >= 10'd255) begin
      o_sum = {w_sl, 8'hFF, 23'd0};
    end else begin
      o_sum = {w_sl, w_hidden ? 8'(w_e_fin) : 8'h00, w_frac};
    end
  end

endmodule

// File: rtl/fp_sum_tree.sv
// Pipelined FP32 adder tree with optional cross-beat accumulation.
// Each accepted beat of NUM_IN operands is reduced pairwise (2i with 2i+1,
// odd trailing element forwarded) through registered levels, then a final
// stage either forwards the tree sum (mode 0) or folds it into an
// accumulator that is emitted and cleared on the last beat (mode 1).
// Ports:
//   clk, rst       : rising-edge clock, async active-high reset
//   input_valid    : beat present on data_in
//   input_last     : final beat of an accumulation group
//   input_ready    : pipeline advancing this cycle (beat accepted if valid)
//   data_in        : NUM_IN packed FP32 operands, operand k at [32k+31:32k]
//   acc_mode       : 0 = per-beat sum, 1 = accumulate until last
//   output_valid   : data_out holds a result
//   output_ready   : downstream accepts the result
//   data_out       : FP32 result
module fp_sum_tree
  import fp_pkg::*;
#(
  parameter int unsigned NUM_IN = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  input_valid,
  input  logic                  input_last,
  output logic                  input_ready,
  input  logic [NUM_IN*32-1:0]  data_in,
  input  logic                  acc_mode,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [31:0]           data_out
);

  localparam int unsigned LEVELS  = fp_levels(NUM_IN);
  localparam int unsigned LATENCY = fp_latency(NUM_IN);

  // Stage data: index 0 is the input register, index l is tree level l.
  logic [31:0] r_lvl [0:LEVELS][0:NUM_IN-1];
  // Sideband for the input stage and each tree level (LATENCY-1 stages).
  beat_ctrl_t  r_ctl [0:LATENCY-2];

  logic        w_adv;
  beat_ctrl_t  w_in_ctl;
  beat_ctrl_t  w_tree_ctl;
  logic [31:0] w_tree;
  logic [31:0] w_acc_sum;
  logic [31:0] r_acc;
  logic [31:0] r_data_out;
  logic        r_out_valid;

  // Whole pipeline moves together whenever the output slot can be refilled.
  assign w_adv        = output_ready | ~r_out_valid;
  assign input_ready  = w_adv;
  assign output_valid = r_out_valid;
  assign data_out     = r_data_out;

  always_comb begin
    w_in_ctl       = '0;
    w_in_ctl.valid = input_valid;
    w_in_ctl.last  = input_last;
    w_in_ctl.mode  = acc_mode;
  end

  // Input stage sideband.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctl[0] <= '0;
    end else if (w_adv) begin
      r_ctl[0] <= w_in_ctl;
    end
  end

  // Input stage operands.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_stage0
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_lvl[0][i] <= 32'h0;
      end else if (w_adv) begin
        r_lvl[0][i] <= data_in[32*i +: 32];
      end
    end
  end

  // Reduction levels: fixed pairing order, one register rank per level.
  for (genvar l = 1; l <= LEVELS; l++) begin : g_level
    localparam int unsigned W_PREV = fp_level_width(NUM_IN, l - 1);
    localparam int unsigned W_CUR  = fp_level_width(NUM_IN, l);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_ctl[l] <= '0;
      end else if (w_adv) begin
        r_ctl[l] <= r_ctl[l-1];
      end
    end

    for (genvar i = 0; i < NUM_IN; i++) begin : g_node
      if (i < W_CUR) begin : g_live
        logic [31:0] w_node;

        if (2*i + 1 < W_PREV) begin : g_add
          fp_adder u_add (
            .i_a        (r_lvl[l-1][2*i]),
            .i_b        (r_lvl[l-1][2*i+1]),
            .AddBar_Sub (1'b0),
            .o_sum      (w_node)
          );
        end else begin : g_pass
          // Odd trailing element rides to the next level untouched.
          assign w_node = r_lvl[l-1][2*i];
        end

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_lvl[l][i] <= 32'h0;
          end else if (w_adv) begin
            r_lvl[l][i] <= w_node;
          end
        end
      end else begin : g_idle
        // Slots beyond this level's width carry nothing.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_lvl[l][i] <= 32'h0;
          end else begin
            r_lvl[l][i] <= 32'h0;
          end
        end
      end
    end
  end

  assign w_tree     = r_lvl[LEVELS][0];
  assign w_tree_ctl = r_ctl[LEVELS];

  fp_adder u_acc_add (
    .i_a        (r_acc),
    .i_b        (w_tree),
    .AddBar_Sub (1'b0),
    .o_sum      (w_acc_sum)
  );

  // Final stage: forward (mode 0) or accumulate and emit on last (mode 1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= FP_ZERO;
      r_data_out  <= 32'h0;
      r_out_valid <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= 1'b0;
      if (w_tree_ctl.valid) begin
        if (!w_tree_ctl.mode) begin
          r_out_valid <= 1'b1;
          r_data_out  <= w_tree;
        end else if (w_tree_ctl.last) begin
          r_out_valid <= 1'b1;
          r_data_out  <= w_acc_sum;
          r_acc       <= FP_ZERO;
        end else begin
          r_acc <= w_acc_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_sum_tree.sv
// Directed testbench for fp_sum_tree: a NUM_IN=10 instance for most
// scenarios and a NUM_IN=8 instance for the back-to-back streaming case.
module tb_fp_sum_tree;
  import fp_pkg::*;

  localparam int unsigned N  = 10;
  localparam int unsigned N8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             in_valid, in_last, in_ready, in_mode;
  logic [N*32-1:0]  in_data;
  logic             out_valid, out_ready;
  logic [31:0]      data_out;

  logic             d8_valid, d8_last, d8_ready, d8_mode;
  logic [N8*32-1:0] d8_data;
  logic             d8_ovalid, d8_oready;
  logic [31:0]      d8_dout;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] STALL_IN [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                           32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  localparam logic [31:0] STALL_EXP [8] = '{32'h41200000, 32'h41A00000, 32'h41F00000, 32'h42200000,
                                            32'h42480000, 32'h42700000, 32'h428C0000, 32'h42A00000};

  fp_sum_tree #(.NUM_IN(N)) dut (
    .clk (clk), .rst (rst),
    .input_valid (in_valid), .input_last (in_last), .input_ready (in_ready),
    .data_in (in_data), .acc_mode (in_mode),
    .output_valid (out_valid), .output_ready (out_ready), .data_out (data_out)
  );

  fp_sum_tree #(.NUM_IN(N8)) dut8 (
    .clk (clk), .rst (rst),
    .input_valid (d8_valid), .input_last (d8_last), .input_ready (d8_ready),
    .data_in (d8_data), .acc_mode (d8_mode),
    .output_valid (d8_ovalid), .output_ready (d8_oready), .data_out (d8_dout)
  );

  function automatic logic [N*32-1:0] fill(input logic [31:0] v);
    logic [N*32-1:0] r;
    for (int k = 0; k < N; k++) r[32*k +: 32] = v;
    return r;
  endfunction

  // Present one beat for one clock (pipeline assumed ready).
  task automatic send(input logic [N*32-1:0] d, input logic mode, input logic last);
    in_data  = d;
    in_mode  = mode;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait for output_valid; lat counts edges with the acceptance edge as 1.
  task automatic wait_out(output logic [31:0] d, output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    d = data_out;
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || data_out !== 32'h0) begin
      n_err++; $display("FAIL reset_hold: valid=%b data=%h required valid=0 data=00000000", out_valid, data_out);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0 || data_out !== 32'h0) begin
      n_err++; $display("FAIL reset_out: valid=%b data=%h required valid=0 data=00000000", out_valid, data_out);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b required 1", in_ready);
    end
    n_vec++;
    if (d8_ovalid !== 1'b0 || d8_dout !== 32'h0 || d8_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_dut8: valid=%b data=%h ready=%b required 0/00000000/1", d8_ovalid, d8_dout, d8_ready);
    end
  endtask

  task automatic test_single_beat();
    logic [31:0] d;
    int lat;
    out_ready = 1'b1;
    send(fill(FP_ONE), 1'b0, 1'b0);
    wait_out(d, lat);
    n_vec++;
    if (lat != 6) begin
      n_err++; $display("FAIL single_latency: got %0d required 6", lat);
    end
    n_vec++;
    if (d !== 32'h41200000) begin
      n_err++; $display("FAIL single_data: got %h required 41200000", d);
    end
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL single_once: valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_patterns();
    logic [N*32-1:0] v;
    logic [31:0] exp_d, d;
    int lat;
    out_ready = 1'b1;
    for (int p = 0; p < 6; p++) begin
      v = '0;
      case (p)
        0: begin v = fill(32'h3F000000); exp_d = 32'h40A00000; end
        1: begin v = fill(32'hBF800000); exp_d = 32'hC1200000; end
        2: begin v[32*9 +: 32] = 32'h40400000; exp_d = 32'h40400000; end
        3: begin
             for (int k = 0; k < N; k++) v[32*k +: 32] = k[0] ? 32'hC0400000 : 32'h40400000;
             exp_d = 32'h00000000;
           end
        4: begin v[31:0] = FP_ONE; v[63:32] = 32'h33800001; exp_d = 32'h3F800001; end
        default: begin v[31:0] = FP_ONE; v[63:32] = 32'h33800000; exp_d = 32'h3F800000; end
      endcase
      send(v, 1'b0, 1'b0);
      wait_out(d, lat);
      n_vec++;
      if (d !== exp_d || lat != 6) begin
        n_err++; $display("FAIL pattern_%0d: got %h lat %0d required %h lat 6", p, d, lat, exp_d);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_accumulate();
    logic [31:0] d;
    int lat;
    out_ready = 1'b1;
    send(fill(FP_ONE), 1'b1, 1'b0);
    send(fill(FP_ONE), 1'b1, 1'b0);
    send(fill(FP_ONE), 1'b1, 1'b1);
    wait_out(d, lat);
    n_vec++;
    if (lat != 6 || d !== 32'h41F00000) begin
      n_err++; $display("FAIL acc_group: got %h lat %0d required 41f00000 lat 6", d, lat);
    end
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL acc_single_out: valid=%b required 0", out_valid);
    end
    send(fill(FP_ONE), 1'b1, 1'b1);
    wait_out(d, lat);
    n_vec++;
    if (lat != 6 || d !== 32'h41200000) begin
      n_err++; $display("FAIL acc_restart: got %h lat %0d required 41200000 lat 6", d, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mode_mix();
    logic [31:0] d;
    int lat;
    out_ready = 1'b1;
    send(fill(FP_ONE), 1'b1, 1'b0);
    send(fill(32'h3F000000), 1'b0, 1'b0);
    send(fill(FP_ONE), 1'b1, 1'b1);
    wait_out(d, lat);
    n_vec++;
    if (lat != 5 || d !== 32'h40A00000) begin
      n_err++; $display("FAIL mix_passthru: got %h lat %0d required 40a00000 lat 5", d, lat);
    end
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b1 || data_out !== 32'h41A00000) begin
      n_err++; $display("FAIL mix_group: valid=%b data=%h required 1 41a00000", out_valid, data_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back8();
    d8_data   = {32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000,
                 32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    d8_mode   = 1'b0;
    d8_last   = 1'b0;
    d8_oready = 1'b1;
    d8_valid  = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    d8_valid = 1'b0;
    n_vec++;
    if (d8_ovalid !== 1'b0) begin
      n_err++; $display("FAIL b2b_early: valid=%b required 0", d8_ovalid);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if (d8_ovalid !== 1'b1 || d8_dout !== 32'h42100000) begin
        n_err++; $display("FAIL b2b_result_%0d: valid=%b data=%h required 1 42100000", k, d8_ovalid, d8_dout);
      end
    end
    @(posedge clk); #1;
    n_vec++;
    if (d8_ovalid !== 1'b0) begin
      n_err++; $display("FAIL b2b_extra: valid=%b required 0", d8_ovalid);
    end
  endtask

  task automatic test_stall();
    int sent = 0;
    int recv = 0;
    logic hs_in;
    in_mode = 1'b0;
    in_last = 1'b0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      in_valid  = (sent < 8);
      in_data   = (sent < 8) ? fill(STALL_IN[sent]) : '0;
      out_ready = !(cyc >= 8 && cyc < 13);
      @(negedge clk);
      if (!out_ready) begin
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || data_out !== STALL_EXP[recv]) begin
          n_err++; $display("FAIL stall_hold_c%0d: ready=%b valid=%b data=%h required 0 1 %h",
                            cyc, in_ready, out_valid, data_out, STALL_EXP[recv]);
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (data_out !== STALL_EXP[recv]) begin
          n_err++; $display("FAIL stall_result_%0d: got %h required %h", recv, data_out, STALL_EXP[recv]);
        end
        recv++;
      end
      hs_in = in_valid & in_ready;
      @(posedge clk); #1;
      if (hs_in) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_vec++;
    if (sent != 8 || recv != 8) begin
      n_err++; $display("FAIL stall_count: sent %0d recv %0d required 8 8", sent, recv);
    end
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_dup: valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_group();
    logic [31:0] d;
    int lat;
    out_ready = 1'b1;
    send(fill(FP_ONE), 1'b0, 1'b0);
    send(fill(32'h40400000), 1'b1, 1'b0);
    send(fill(32'h40400000), 1'b1, 1'b0);
    out_ready = 1'b0;
    wait_out(d, lat);
    n_vec++;
    if (lat < 0) begin
      n_err++; $display("FAIL rstmid_setup: no output observed, required output before reset");
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || data_out !== 32'h0) begin
      n_err++; $display("FAIL rstmid_async: valid=%b data=%h required 0 00000000", out_valid, data_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(fill(FP_ONE), 1'b1, 1'b1);
    wait_out(d, lat);
    n_vec++;
    if (lat != 6 || d !== 32'h41200000) begin
      n_err++; $display("FAIL rstmid_fresh: got %h lat %0d required 41200000 lat 6", d, lat);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_mode   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    d8_valid  = 1'b0;
    d8_last   = 1'b0;
    d8_mode   = 1'b0;
    d8_data   = '0;
    d8_oready = 1'b1;

    test_reset();
    test_single_beat();
    test_patterns();
    test_accumulate();
    test_mode_mix();
    test_back_to_back8();
    test_stall();
    test_reset_mid_group();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
